// File: rtl/conv_pkg.sv
// Shared parameters and types for the 5x5 convolution row engine and the pooling stage.
package conv_pkg;
  localparam int IMG_W  = 10;
  localparam int IMG_H  = 30;
  localparam int K      = 5;
  localparam int PIX_W  = 8;
  localparam int WGT_W  = 8;
  localparam int ACC_W  = 21;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int TAPS   = K * K;
  localparam int PROD_W = PIX_W + 1 + WGT_W;
  localparam int ROW_W  = IMG_W * PIX_W;
  localparam int RS_W   = $clog2(IMG_H + 1);
  localparam int WI_W   = $clog2(TAPS);

  typedef logic        [PIX_W-1:0]  pixel_t;
  typedef logic signed [WGT_W-1:0]  weight_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic        [ROW_W-1:0]  row_t;
  typedef logic        [RS_W-1:0]   rcnt_t;

  // Unsigned pixel times signed weight; the zero bit keeps the pixel non-negative.
  function automatic prod_t mul_px(input pixel_t p, input weight_t w);
    return $signed({1'b0, p}) * w;
  endfunction
endpackage

// File: rtl/conv5x5_dot.sv
// One 25-tap dot product: registered products, then a registered sum.
// Optional build macro CONV_RELU_EN clamps negative sums to zero.
module conv5x5_dot
  import conv_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en_mul,
  input  logic    en_sum,
  input  pixel_t  pix [TAPS],
  input  weight_t wgt [TAPS],
  output acc_t    sum
);
  prod_t prods [TAPS];
  acc_t  total;
  acc_t  sum_next;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    total = '0;
    for (int i = 0; i < TAPS; i++) total = total + acc_t'(prods[i]);
`ifdef CONV_RELU_EN
    sum_next = total[ACC_W-1] ? '0 : total;
`else
    sum_next = total;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) prods[i] <= '0;
      sum <= '0;
    end else begin
      if (en_mul) for (int i = 0; i < TAPS; i++) prods[i] <= mul_px(pix[i], wgt[i]);
      if (en_sum) sum <= sum_next;
    end
  end
endmodule

// File: rtl/conv5x5_row_engine.sv
// Sliding 5-row window over 10-pixel rows; emits 6 parallel 5x5 convolutions per full window.
// Optional build macro CONV_RELU_EN (handled in conv5x5_dot) clamps results at zero.
module conv5x5_row_engine
  import conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   row_valid,
  input  logic [ROW_W-1:0]       row_data,
  input  logic                   w_load,
  input  logic [WGT_W-1:0]       w_data,
  output logic                   kernel_ready,
  output logic                   conv_valid,
  output logic [OUT_W*ACC_W-1:0] conv_out,
  output logic [RS_W-1:0]        out_row,
  output logic                   frame_done
);
  row_t            win     [K];
  weight_t         weights [TAPS];
  logic [WI_W-1:0] w_idx;
  rcnt_t           rows_seen;
  rcnt_t           rows_next;
  rcnt_t           orow0, orow1;
  logic            accept, fire, fire_q, v1;

  // Saturated frames ignore extra rows unless a new frame begins on this row.
  assign accept    = row_valid && (frame_start || rows_seen != rcnt_t'(IMG_H));
  assign rows_next = frame_start ? rcnt_t'(1) : rows_seen + rcnt_t'(1);
  assign fire      = accept && kernel_ready && (rows_next >= rcnt_t'(K));

  // NOTE: weights and window are reset too, so a mid-frame reset drops kernel_ready and leaves no stale rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++)    win[i]     <= '0;
      for (int i = 0; i < TAPS; i++) weights[i] <= '0;
      w_idx        <= '0;
      kernel_ready <= 1'b0;
      rows_seen    <= '0;
      fire_q       <= 1'b0;
      v1           <= 1'b0;
      orow0        <= '0;
      orow1        <= '0;
      conv_valid   <= 1'b0;
      out_row      <= '0;
      frame_done   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
      if (w_load) begin
        weights[w_idx] <= weight_t'(w_data);
        if (w_idx == WI_W'(TAPS - 1)) begin
          w_idx        <= '0;
          kernel_ready <= 1'b1;
        end else begin
          w_idx <= w_idx + WI_W'(1);
        end
      end
      if (accept) begin
        for (int i = 0; i < K - 1; i++) win[i] <= win[i+1];
        win[K-1]  <= row_data;
        rows_seen <= rows_next;
      end else if (frame_start) begin
        rows_seen <= '0;
      end
      fire_q <= fire;
      if (fire) orow0 <= rows_next - rcnt_t'(K);
      v1 <= fire_q;
      if (fire_q) orow1 <= orow0;
      conv_valid <= v1;
      if (v1) out_row <= orow1;
      frame_done <= v1 && (orow1 == rcnt_t'(IMG_H - K));
    end
  end

  for (genvar j = 0; j < OUT_W; j++) begin : g_dot
    pixel_t pix [TAPS];
    acc_t   res;

    // Kernel row r reads win[r] (oldest first), columns j..j+K-1.
    always_comb begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          pix[r*K+c] = win[r][(j+c)*PIX_W +: PIX_W];
    end

    conv5x5_dot u_dot (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_mul (fire_q),
      .en_sum (v1),
      .pix    (pix),
      .wgt    (weights),
      .sum    (res)
    );

    assign conv_out[j*ACC_W +: ACC_W] = res;
  end
endmodule

// File: doc/conv5x5_row_engine.md
Name: conv5x5_row_engine

Overview:
- Downstream compute stage of the image row buffer: consumes one 10-pixel image row per valid cycle and keeps a sliding window of the last 5 rows.
- For every full 5-row window it produces all 6 horizontal 5x5 convolution results in parallel, through a 2-stage pipeline.
- Kernel weights are loaded serially before the frame starts.
- Results feed the downstream activation/pooling stage.

Parameters:
- IMG_W, 10, pixels per row.
- IMG_H, 30, rows per frame.
- K, 5, kernel height and width.
- PIX_W, 8, pixel width (unsigned).
- WGT_W, 8, weight width (two's-complement signed).
- ACC_W, 21, result width (signed); holds 25 * 255 * 128 = 816000.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- frame_start  input  1  pulse: next accepted row is row 0 of a new frame
- row_valid  input  1  row_data valid this cycle
- row_data  input  IMG_W*PIX_W  row pixels; pixel i at bits [i*8+7:i*8]
- w_load  input  1  weight write strobe
- w_data  input  WGT_W  weight value, raster order (r*K+c)
- kernel_ready  output  1  all K*K weights loaded
- conv_valid  output  1  conv_out valid (1-cycle pulse per window)
- conv_out  output  (IMG_W-K+1)*ACC_W  6 signed results; result j at bits [j*ACC_W +: ACC_W]
- out_row  output  5  output row index, 0..IMG_H-K (0..25)
- frame_done  output  1  pulse with the conv_valid of out_row = IMG_H-K

Behaviour:
- Reset values: all outputs 0, window rows 0, rows_seen 0, w_idx 0, weights 0.
- Weight load:
  - On each w_load cycle, w_data is written to weight[w_idx].
  - w_idx counts 0..24 and then wraps to 0.
  - kernel_ready is set on the cycle after the 25th write and stays high until reset. A reload overwrites weights in place.
  - A weight write takes effect for rows accepted on later cycles. Overlapping a write with an in-flight window is not supported.
- Row accept (row_valid=1):
  - Window shifts: win[0] <= win[1], ..., win[K-1] <= row_data; win[K-1] is the newest row.
  - rows_seen increments and saturates at IMG_H.
- frame_start:
  - Clears rows_seen and the output row counter.
  - If it coincides with row_valid, that row counts as row 0 (rows_seen becomes 1).
- Window fire: an accepted row makes rows_seen reach a value >= K while kernel_ready=1.
- Rows beyond IMG_H (rows_seen saturated) are ignored: no shift, no fire.
- Pipeline:
  - Stage 1 registers the 6*25 products. Each product is {1'b0,pixel} * weight, 17-bit signed.
  - Stage 2 registers the sign-extended sum of 25 products per output.
  - conv_valid rises 2 cycles after the accepting edge.
  - Fully pipelined: one row per cycle, with no back-pressure.
- Result j uses window columns j..j+4. Kernel row r is applied to win[r], so r=0 is the oldest row.
- out_row:
  - Equals rows_seen-K at fire time, carried down the pipeline.
  - frame_done pulses when out_row=IMG_H-K.
- Gaps: row_valid may be low on any cycle; the window holds its contents.
- Reset mid-frame clears the pipeline, discarding in-flight results. Weights are also cleared, so kernel_ready=0.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: stage 2 clamps negative sums to 0 before registering conv_out. Latency is unchanged.
- Undefined: raw signed sums are output.

Decomposition:
- Package conv_pkg holds the following, shared with the pooling stage:
  - IMG_W, IMG_H, K, PIX_W, WGT_W, ACC_W
  - derived OUT_W = IMG_W-K+1
  - pixel, weight and accumulator typedefs
- Sub-module conv5x5_dot: one 25-tap multiply stage plus an adder stage (2 registers), instantiated OUT_W times by generate.

Test Plan:
- Load 25 weights of 1, frame_start, then 30 rows with all pixels 1:
  - kernel_ready=1 after the 25th write.
  - conv_valid first 2 cycles after the 5th row; 26 pulses in total.
  - Every result = 25; frame_done with out_row=25.
- Weights all -128, pixels all 255:
  - Without CONV_RELU_EN each result = -816000.
  - With CONV_RELU_EN each result = 0.
- Centre weight only (weight[12]=1), row n pixel i = n*10+i:
  - Result j for out_row m = (m+2)*10 + j + 2, masked to 8 bits.
- row_valid toggled on/off each cycle:
  - Results identical to the back-to-back run, each conv_valid 2 cycles after its row.
- Assert rst_n low after row 12, then reload weights and start a new frame:
  - No stale conv_valid.
  - out_row restarts at 0 after 5 new rows.
- Rows streamed before kernel_ready:
  - No conv_valid.
  - Send 32 rows: rows 31 and 32 are ignored and no 27th result appears.
